instruction_encoder: RTL and testbench

- Streaming RV32I instruction encoder: converts a mnemonic code plus register and immediate operands into a 32-bit machine word. It is the inverse of the pipeline's instruction decoder.
- Sits between the test/boot loader front-end and instruction-memory write port.
- Each accepted word is emitted with a write address (auto-incremented by 4). The block stops when the memory region is full.

---
 rtl/enc_pkg.sv | 65 ++++++
 rtl/instr_pack.sv | 106 ++++++++++
 rtl/instruction_encoder.sv | 92 +++++++++
 tb/tb_instruction_encoder.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared types and RV32I encoding constants for the instruction encoder.
// Operation codes past OP_AUIPC are undefined and flagged as illegal by the packer.
package enc_pkg;

    typedef enum logic [5:0] {
        OP_NOP = 6'd0,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
    } op_t;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_B    = 3'b000;
    localparam logic [2:0] F3_H    = 3'b001;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BU   = 3'b100;
    localparam logic [2:0] F3_HU   = 3'b101;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int SHAMT_MAX = 31;
    localparam int BOFS_MIN  = -4096;
    localparam int BOFS_MAX  = 4094;
    localparam int JOFS_MIN  = -1048576;
    localparam int JOFS_MAX  = 1048574;
    localparam int UIMM_MAX  = 1048575;

    function automatic logic in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: operands in, machine word and illegal flag out.
// Illegal operands and NOP both produce an all-zero word.
module instr_pack
    import enc_pkg::*;
(
    input  op_t         op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    fmt_t        fmt;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        is_shift;
    logic        known;
    logic        bad_imm;
    logic [31:0] packed_word;
    int          simm;

    assign simm = int'(signed'(imm));

    always_comb begin
        fmt      = FMT_R;
        opc      = OPC_OP;
        f3       = F3_ADD;
        f7       = F7_BASE;
        is_shift = 1'b0;
        known    = 1'b1;
        case (op)
            OP_NOP:   fmt = FMT_R;
            OP_ADD:   f3 = F3_ADD;
            OP_SUB:   begin f3 = F3_ADD; f7 = F7_ALT; end
            OP_SLL:   f3 = F3_SLL;
            OP_SLT:   f3 = F3_SLT;
            OP_SLTU:  f3 = F3_SLTU;
            OP_XOR:   f3 = F3_XOR;
            OP_SRL:   f3 = F3_SR;
            OP_SRA:   begin f3 = F3_SR; f7 = F7_ALT; end
            OP_OR:    f3 = F3_OR;
            OP_AND:   f3 = F3_AND;
            OP_ADDI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_ADD;  end
            OP_SLTI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_SLT;  end
            OP_SLTIU: begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_SLTU; end
            OP_XORI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_XOR;  end
            OP_ORI:   begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_OR;   end
            OP_ANDI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_AND;  end
            OP_SLLI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_SLL; is_shift = 1'b1; end
            OP_SRLI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_SR;  is_shift = 1'b1; end
            OP_SRAI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_SR;  is_shift = 1'b1; f7 = F7_ALT; end
            OP_LB:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_B;  end
            OP_LH:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_H;  end
            OP_LW:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_W;  end
            OP_LBU:   begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_BU; end
            OP_LHU:   begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_HU; end
            OP_SB:    begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_B; end
            OP_SH:    begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_H; end
            OP_SW:    begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_W; end
            OP_BEQ:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BEQ;  end
            OP_BNE:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BNE;  end
            OP_BLT:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BLT;  end
            OP_BGE:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BGE;  end
            OP_BLTU:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BLTU; end
            OP_BGEU:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BGEU; end
            OP_JAL:   begin fmt = FMT_J; opc = OPC_JAL; end
            OP_JALR:  begin fmt = FMT_I; opc = OPC_JALR; end
            OP_LUI:   begin fmt = FMT_U; opc = OPC_LUI; end
            OP_AUIPC: begin fmt = FMT_U; opc = OPC_AUIPC; end
            default:  known = 1'b0;
        endcase
    end

    always_comb begin
        bad_imm = 1'b0;
        case (fmt)
            FMT_I:   bad_imm = is_shift ? !in_range(simm, 0, SHAMT_MAX)
                                        : !in_range(simm, IMM12_MIN, IMM12_MAX);
            FMT_S:   bad_imm = !in_range(simm, IMM12_MIN, IMM12_MAX);
            FMT_B:   bad_imm = !in_range(simm, BOFS_MIN, BOFS_MAX) || imm[0];
            FMT_J:   bad_imm = !in_range(simm, JOFS_MIN, JOFS_MAX) || imm[0];
            FMT_U:   bad_imm = !in_range(simm, 0, UIMM_MAX);
            default: bad_imm = 1'b0;
        endcase
    end

    always_comb begin
        case (fmt)
            FMT_R:   packed_word = {f7, rs2, rs1, f3, rd, opc};
            FMT_I:   packed_word = is_shift ? {f7, imm[4:0], rs1, f3, rd, opc}
                                            : {imm[11:0], rs1, f3, rd, opc};
            FMT_S:   packed_word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
            FMT_B:   packed_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
            FMT_U:   packed_word = {imm[19:0], rd, opc};
            FMT_J:   packed_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
            default: packed_word = 32'h0000_0000;
        endcase
    end

    assign illegal = !known || bad_imm;
    assign word    = (illegal || (op == OP_NOP)) ? 32'h0000_0000 : packed_word;

endmodule

// File: rtl/instruction_encoder.sv
// Streaming RV32I encoder: one registered output word per accepted bundle (latency 1),
// addressed sequentially from BASE_ADDR; output holds under backpressure, stops when the region fills.
module instruction_encoder
    import enc_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  op_t         op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [31:0] out_addr,
    output logic        full,
    input  logic        clear,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam logic [0:0]  ST_RUN    = 1'b0;
    localparam logic [0:0]  ST_FULL   = 1'b1;
    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'((MEM_DEPTH - 1) * 4);

    logic [0:0]  state;
    logic [31:0] pack_word;
    logic        pack_illegal;
    logic        at_last;
    logic        out_hs;
    logic        accept;

    instr_pack u_pack (
        .op      (op),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .imm     (imm),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    // Once the final word of the region sits in the output register nothing more may enter.
    assign at_last  = (out_addr == LAST_ADDR);
    assign in_ready = (state == ST_RUN) && !(out_valid && at_last) && (!out_valid || out_ready);
    assign out_hs   = out_valid && out_ready;
    assign accept   = in_valid && in_ready;
    assign full     = (state == ST_FULL);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RUN;
            out_valid <= 1'b0;
            out_word  <= 32'h0000_0000;
            out_addr  <= BASE_ADDR;
            err       <= 1'b0;
            err_count <= 8'd0;
        end else if (clear) begin
            state     <= ST_RUN;
            out_valid <= 1'b0;
            out_word  <= 32'h0000_0000;
            out_addr  <= BASE_ADDR;
            err       <= 1'b0;
            err_count <= 8'd0;
        end else begin
            if (out_hs) begin
                if (at_last) begin
                    state <= ST_FULL;
                end else begin
                    out_addr <= out_addr + 32'd4;
                end
            end
            if (accept) begin
                out_valid <= 1'b1;
                out_word  <= pack_word;
                if (pack_illegal) begin
                    err       <= 1'b1;
                    err_count <= (err_count == 8'hFF) ? err_count : err_count + 8'd1;
                end
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: directed vectors, fill/stall/clear, randomized traffic, async reset.
module tb_instruction_encoder;
    import enc_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam logic [31:0] LAST  = BASE + 32'((DEPTH - 1) * 4);

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    op_t         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [31:0] out_addr;
    logic        full;
    logic        clear;
    logic        err;
    logic [7:0]  err_count;

    instruction_encoder #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_addr  (out_addr),
        .full      (full),
        .clear     (clear),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state: pending output words plus region/error bookkeeping.
    logic [31:0] q_word[$];
    logic [31:0] seen_word[$];
    logic [31:0] seen_addr[$];
    logic [31:0] m_addr;
    bit          m_full;
    int          m_errs;
    bit          last_acc;

    task automatic model_reset();
        q_word.delete();
        m_addr = BASE;
        m_full = 1'b0;
        m_errs = 0;
    endtask

    function automatic logic [32:0] ref_encode(input op_t o, input logic [4:0] d, input logic [4:0] s1,
                                               input logic [4:0] s2, input logic [31:0] iv);
        longint v, w, opc, f3, f7, rdl, r1, r2;
        byte    fm;
        bit     bad;
        v = longint'($signed(iv));
        rdl = longint'(d); r1 = longint'(s1); r2 = longint'(s2);
        opc = 0; f3 = 0; f7 = 0; w = 0; bad = 1'b0; fm = "X";
        case (o)
            OP_NOP:   fm = "N";
            OP_ADD:   begin fm = "R"; opc = 'h33; end
            OP_SUB:   begin fm = "R"; opc = 'h33; f7 = 'h20; end
            OP_SLL:   begin fm = "R"; opc = 'h33; f3 = 1; end
            OP_SLT:   begin fm = "R"; opc = 'h33; f3 = 2; end
            OP_SLTU:  begin fm = "R"; opc = 'h33; f3 = 3; end
            OP_XOR:   begin fm = "R"; opc = 'h33; f3 = 4; end
            OP_SRL:   begin fm = "R"; opc = 'h33; f3 = 5; end
            OP_SRA:   begin fm = "R"; opc = 'h33; f3 = 5; f7 = 'h20; end
            OP_OR:    begin fm = "R"; opc = 'h33; f3 = 6; end
            OP_AND:   begin fm = "R"; opc = 'h33; f3 = 7; end
            OP_ADDI:  begin fm = "I"; opc = 'h13; end
            OP_SLTI:  begin fm = "I"; opc = 'h13; f3 = 2; end
            OP_SLTIU: begin fm = "I"; opc = 'h13; f3 = 3; end
            OP_XORI:  begin fm = "I"; opc = 'h13; f3 = 4; end
            OP_ORI:   begin fm = "I"; opc = 'h13; f3 = 6; end
            OP_ANDI:  begin fm = "I"; opc = 'h13; f3 = 7; end
            OP_SLLI:  begin fm = "H"; opc = 'h13; f3 = 1; end
            OP_SRLI:  begin fm = "H"; opc = 'h13; f3 = 5; end
            OP_SRAI:  begin fm = "H"; opc = 'h13; f3 = 5; f7 = 'h20; end
            OP_LB:    begin fm = "I"; opc = 'h03; end
            OP_LH:    begin fm = "I"; opc = 'h03; f3 = 1; end
            OP_LW:    begin fm = "I"; opc = 'h03; f3 = 2; end
            OP_LBU:   begin fm = "I"; opc = 'h03; f3 = 4; end
            OP_LHU:   begin fm = "I"; opc = 'h03; f3 = 5; end
            OP_SB:    begin fm = "S"; opc = 'h23; end
            OP_SH:    begin fm = "S"; opc = 'h23; f3 = 1; end
            OP_SW:    begin fm = "S"; opc = 'h23; f3 = 2; end
            OP_BEQ:   begin fm = "B"; opc = 'h63; end
            OP_BNE:   begin fm = "B"; opc = 'h63; f3 = 1; end
            OP_BLT:   begin fm = "B"; opc = 'h63; f3 = 4; end
            OP_BGE:   begin fm = "B"; opc = 'h63; f3 = 5; end
            OP_BLTU:  begin fm = "B"; opc = 'h63; f3 = 6; end
            OP_BGEU:  begin fm = "B"; opc = 'h63; f3 = 7; end
            OP_JAL:   begin fm = "J"; opc = 'h6F; end
            OP_JALR:  begin fm = "I"; opc = 'h67; end
            OP_LUI:   begin fm = "U"; opc = 'h37; end
            OP_AUIPC: begin fm = "U"; opc = 'h17; end
            default:  fm = "X";
        endcase
        case (fm)
            "N": w = 0;
            "R": w = (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (rdl << 7) | opc;
            "I": begin
                bad = (v < -2048) || (v > 2047);
                w = ((v & 'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (rdl << 7) | opc;
            end
            "H": begin
                bad = (v < 0) || (v > 31);
                w = (f7 << 25) | ((v & 'h1F) << 20) | (r1 << 15) | (f3 << 12) | (rdl << 7) | opc;
            end
            "S": begin
                bad = (v < -2048) || (v > 2047);
                w = (((v >> 5) & 'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12)
                    | ((v & 'h1F) << 7) | opc;
            end
            "B": begin
                bad = (v < -4096) || (v > 4094) || ((v & 1) != 0);
                w = (((v >> 12) & 1) << 31) | (((v >> 5) & 'h3F) << 25) | (r2 << 20) | (r1 << 15)
                    | (f3 << 12) | (((v >> 1) & 'hF) << 8) | (((v >> 11) & 1) << 7) | opc;
            end
            "U": begin
                bad = (v < 0) || (v > 1048575);
                w = ((v & 'hFFFFF) << 12) | (rdl << 7) | opc;
            end
            "J": begin
                bad = (v < -1048576) || (v > 1048574) || ((v & 1) != 0);
                w = (((v >> 20) & 1) << 31) | (((v >> 1) & 'h3FF) << 21) | (((v >> 11) & 1) << 20)
                    | (((v >> 12) & 'hFF) << 12) | (rdl << 7) | opc;
            end
            default: bad = 1'b1;
        endcase
        if (bad) w = 0;
        return {bad, w[31:0]};
    endfunction

    // One clock: compare DUT against the model at the falling edge, then advance the model.
    task automatic cycle_check();
        bit          exp_rdy, hs, acc;
        logic [32:0] r;
        @(negedge clock);
        exp_rdy = !m_full && !((q_word.size() != 0) && (m_addr == LAST))
                  && ((q_word.size() == 0) || out_ready);
        check("out_valid", out_valid, q_word.size() != 0);
        check("in_ready", in_ready, exp_rdy);
        if (q_word.size() != 0) begin
            check("out_word", out_word, q_word[0]);
            check("out_addr", out_addr, m_addr);
        end
        check("full", full, m_full);
        check("err", err, m_errs != 0);
        check("err_count", err_count, (m_errs > 255) ? 255 : m_errs);
        hs = (q_word.size() != 0) && out_ready;
        acc = in_valid && exp_rdy && !clear;
        last_acc = acc;
        if (clear) begin
            model_reset();
        end else begin
            if (hs) begin
                seen_word.push_back(out_word);
                seen_addr.push_back(out_addr);
                void'(q_word.pop_front());
                if (m_addr == LAST) m_full = 1'b1;
                else m_addr = m_addr + 32'd4;
            end
            if (acc) begin
                r = ref_encode(op, rd, rs1, rs2, imm);
                q_word.push_back(r[31:0]);
                if (r[32]) m_errs++;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic send(input op_t o, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] iv, input bit rdy);
        op = o; rd = d; rs1 = s1; rs2 = s2; imm = iv;
        in_valid = 1'b1;
        out_ready = rdy;
        last_acc = 1'b0;
        for (int n = 0; n < 20 && !last_acc; n++) cycle_check();
        check("send_accepted", last_acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic random_bundle();
        op  = op_t'(6'($urandom_range(0, 45)));
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        case ($urandom_range(0, 4))
            0:       imm = 32'(int'($urandom_range(0, 4095)) - 2048);
            1:       imm = 32'(int'($urandom_range(0, 16383)) - 8192);
            2:       imm = 32'(int'($urandom_range(0, 2097151)) - 1048576);
            3:       imm = 32'($urandom_range(0, 40));
            default: imm = $urandom;
        endcase
    endtask

    initial begin
        int accepted;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clear = 1'b0;
        op = OP_NOP; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_word", out_word, 32'h0);
        check("rst_out_addr", out_addr, BASE);
        check("rst_full", full, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_err_count", err_count, 8'd0);
        model_reset();
        reset_n = 1'b1;
        cycle_check();

        // Directed encodings, including two illegal bundles.
        send(OP_ADD,  5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1);
        send(OP_SW,   5'd0, 5'd1, 5'd2, 32'd8, 1'b1);
        send(OP_BEQ,  5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b1);
        send(OP_LUI,  5'd5, 5'd0, 5'd0, 32'h0001_2345, 1'b1);
        send(OP_ADDI, 5'd1, 5'd1, 5'd0, 32'd2048, 1'b1);
        send(OP_BEQ,  5'd0, 5'd1, 5'd2, 32'd3, 1'b1);
        repeat (3) cycle_check();
        check("dir_count", seen_word.size(), 7);
        if (seen_word.size() >= 7) begin
            check("add_word",  seen_word[0], 32'h002081B3);
            check("add_addr",  seen_addr[0], BASE);
            check("addi_word", seen_word[1], 32'hFFF00093);
            check("sw_word",   seen_word[2], 32'h0020A423);
            check("sw_addr",   seen_addr[2], BASE + 32'd8);
            check("beq_word",  seen_word[3], 32'hFE208EE3);
            check("lui_word",  seen_word[4], 32'h123452B7);
            check("ill_addi",  seen_word[5], 32'h0);
            check("ill_beq",   seen_word[6], 32'h0);
            check("ill_addr",  seen_addr[6], BASE + 32'd24);
        end
        check("dir_err", err, 1'b1);
        check("dir_err_count", err_count, 8'd2);

        clear = 1'b1;
        cycle_check();
        clear = 1'b0;
        check("clr_addr", out_addr, BASE);
        check("clr_err", err, 1'b0);
        check("clr_err_count", err_count, 8'd0);

        // Fill the region with a mid-stream stall; the extra bundle must stay out.
        seen_word.delete(); seen_addr.delete();
        accepted = 0;
        in_valid = 1'b1; op = OP_ADDI; rs1 = 5'd2; rs2 = 5'd0;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 3 && c < 6);
            rd  = 5'(accepted);
            imm = 32'(accepted * 3);
            cycle_check();
            if (last_acc) accepted++;
        end
        check("fill_accepted", accepted, DEPTH);
        check("fill_handshakes", seen_word.size(), DEPTH);
        check("fill_full", full, 1'b1);
        check("fill_in_ready", in_ready, 1'b0);
        check("fill_last_addr", out_addr, LAST);
        clear = 1'b1;
        cycle_check();
        clear = 1'b0;
        check("clr2_addr", out_addr, BASE);
        check("clr2_full", full, 1'b0);
        check("clr2_valid", out_valid, 1'b0);
        in_valid = 1'b0;
        repeat (2) cycle_check();

        // Randomized traffic with occasional clears.
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 59) == 0);
            random_bundle();
            cycle_check();
        end

        // Asynchronous reset while a word is pending.
        in_valid = 1'b0; out_ready = 1'b1; clear = 1'b1;
        cycle_check();
        clear = 1'b0;
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5000, 1'b0);
        cycle_check();
        check("pre_rst_valid", out_valid, 1'b1);
        check("pre_rst_err", err, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_out_word", out_word, 32'h0);
        check("arst_out_addr", out_addr, BASE);
        check("arst_full", full, 1'b0);
        check("arst_err", err, 1'b0);
        check("arst_err_count", err_count, 8'd0);
        model_reset();
        reset_n = 1'b1;
        out_ready = 1'b1;
        cycle_check();
        send(OP_SUB, 5'd7, 5'd8, 5'd9, 32'd0, 1'b1);
        repeat (3) cycle_check();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
